// File: rtl/led_drv_pkg.sv
// Shared mode codes, breathing direction type and PWM helper for the LED mode driver.
package led_drv_pkg;

   localparam logic [1:0] MODE_OFF     = 2'd0;
   localparam logic [1:0] MODE_ON      = 2'd1;
   localparam logic [1:0] MODE_BLINK   = 2'd2;
   localparam logic [1:0] MODE_BREATHE = 2'd3;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_t;

   function automatic int pwm_max(input int bits);
      return (1 << bits) - 1;
   endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler producing a one-cycle registered tick every PRESCALE clocks; restart realigns it.
module led_tick_gen
   import led_drv_pkg::*;
#(
   parameter int PRESCALE = 50000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic restart,
   output logic tick
);

   localparam int            CW   = $clog2(PRESCALE);
   localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

   logic [CW-1:0] cnt;

   // restart wins over a wrap on the same edge, so a pending tick is dropped
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else if (restart) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else if (cnt == LAST) begin
         cnt  <= '0;
         tick <= 1'b1;
      end else begin
         cnt  <= cnt + CW'(1);
         tick <= 1'b0;
      end
   end

endmodule

// File: rtl/led_mode_driver.sv
// Turns the 2-bit PIO mode code into two registered LED pin levels (off/on/blink/breathe).
//
//   dir      | meaning
//   DIR_UP   | breathing duty ramps toward MAX on each tick
//   DIR_DOWN | breathing duty ramps toward 0 on each tick
module led_mode_driver
   import led_drv_pkg::*;
#(
   parameter int PRESCALE    = 50000,
   parameter int BLINK_TICKS = 250,
   parameter int PWM_BITS    = 8,
   parameter int ACTIVE_LOW  = 0
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] led_cmd,
   output logic [1:0] led_out,
   output logic       tick
);

   localparam logic [PWM_BITS-1:0] MAX        = PWM_BITS'(pwm_max(PWM_BITS));
   localparam logic [PWM_BITS-1:0] ONE        = PWM_BITS'(1);
   localparam int                  BW         = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
   localparam logic [BW-1:0]       BLINK_LAST = BW'(BLINK_TICKS - 1);
   localparam logic [1:0]          POL        = (ACTIVE_LOW != 0) ? 2'b11 : 2'b00;

   logic [1:0]          mode_q;
   logic                restart;
   logic [BW-1:0]       blink_cnt;
   logic [BW-1:0]       blink_nxt;
   logic                phase;
   logic                phase_nxt;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic [PWM_BITS-1:0] duty;
   logic [PWM_BITS-1:0] duty_nxt;
   dir_t                dir;
   dir_t                dir_nxt;
   logic [1:0]          pins;

   assign restart = (led_cmd != mode_q);

   led_tick_gen #(
      .PRESCALE (PRESCALE)
   ) u_tick_gen (
      .clk     (clk),
      .reset_n (reset_n),
      .restart (restart),
      .tick    (tick)
   );

   always_comb begin
      blink_nxt = blink_cnt;
      phase_nxt = phase;
      duty_nxt  = duty;
      dir_nxt   = dir;
      if (restart) begin
         blink_nxt = '0;
         phase_nxt = 1'b0;
         duty_nxt  = '0;
         dir_nxt   = DIR_UP;
      end else if (tick) begin
         if (mode_q == MODE_BLINK) begin
            if (blink_cnt == BLINK_LAST) begin
               blink_nxt = '0;
               phase_nxt = ~phase;
            end else begin
               blink_nxt = blink_cnt + BW'(1);
            end
         end
         // ends of the triangle bounce straight to the neighbouring value
         if (mode_q == MODE_BREATHE) begin
            if (dir == DIR_UP) begin
               if (duty == MAX) begin
                  dir_nxt  = DIR_DOWN;
                  duty_nxt = MAX - ONE;
               end else begin
                  duty_nxt = duty + ONE;
               end
            end else begin
               if (duty == '0) begin
                  dir_nxt  = DIR_UP;
                  duty_nxt = ONE;
               end else begin
                  duty_nxt = duty - ONE;
               end
            end
         end
      end
   end

   always_comb begin
      pins = 2'b00;
      case (mode_q)
         MODE_OFF:   pins = 2'b00;
         MODE_ON:    pins = 2'b11;
         MODE_BLINK: pins = {~phase, phase};
         default:    pins = {(pwm_cnt >= duty), (pwm_cnt < duty)};
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mode_q    <= MODE_ON;
         led_out   <= 2'b11 ^ POL;
         blink_cnt <= '0;
         phase     <= 1'b0;
         pwm_cnt   <= '0;
         duty      <= '0;
         dir       <= DIR_UP;
      end else begin
         mode_q    <= led_cmd;
         led_out   <= pins ^ POL;
         blink_cnt <= blink_nxt;
         phase     <= phase_nxt;
         pwm_cnt   <= pwm_cnt + ONE;
         duty      <= duty_nxt;
         dir       <= dir_nxt;
      end
   end

endmodule

// File: tb/tb_led_mode_driver.sv
// Bench for led_mode_driver: directed vector table, hand sequences and random mode changes vs a closed-form model.
module tb_led_mode_driver;

   localparam int PRE  = 4;
   localparam int BT   = 3;
   localparam int BITS = 3;
   localparam int MAXV = 7;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [1:0] led_cmd;
   logic [1:0] out_hi;
   logic [1:0] out_lo;
   logic       tick_hi;
   logic       tick_lo;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   led_mode_driver #(.PRESCALE(PRE), .BLINK_TICKS(BT), .PWM_BITS(BITS), .ACTIVE_LOW(0)) dut_hi (
      .clk(clk), .reset_n(reset_n), .led_cmd(led_cmd), .led_out(out_hi), .tick(tick_hi));

   led_mode_driver #(.PRESCALE(PRE), .BLINK_TICKS(BT), .PWM_BITS(BITS), .ACTIVE_LOW(1)) dut_lo (
      .clk(clk), .reset_n(reset_n), .led_cmd(led_cmd), .led_out(out_lo), .tick(tick_lo));

   // model: mode, edges since last restart (or reset), free-running pwm count
   int         m_mode;
   int         m_j;
   int         m_pwm;
   logic [1:0] m_out;
   logic       m_tick;

   function automatic int steps_of(input int j);
      return (j >= 1) ? (j - 1) / PRE : 0;
   endfunction

   function automatic int duty_of(input int n);
      int p;
      p = n % (2 * MAXV);
      return (p <= MAXV) ? p : 2 * MAXV - p;
   endfunction

   function automatic logic [1:0] mode_out(input int mode, input int j, input int pwm);
      int n;
      int duty;
      logic [1:0] r;
      n    = steps_of(j);
      duty = duty_of(n);
      case (mode)
         0:       r = 2'b00;
         1:       r = 2'b11;
         2:       r = (((n / BT) % 2) == 1) ? 2'b01 : 2'b10;
         default: r = {(pwm >= duty), (pwm < duty)};
      endcase
      return r;
   endfunction

   task automatic model_reset();
      m_mode = 1;
      m_j    = 0;
      m_pwm  = 0;
      m_out  = 2'b11;
      m_tick = 1'b0;
   endtask

   task automatic model_edge(input int cmd);
      m_out  = mode_out(m_mode, m_j, m_pwm);
      m_j    = (cmd != m_mode) ? 0 : m_j + 1;
      m_mode = cmd;
      m_pwm  = (m_pwm + 1) % (MAXV + 1);
      m_tick = (m_j > 0) && ((m_j % PRE) == 0);
   endtask

   task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all();
      check("led_out", out_hi, m_out);
      check("led_out_active_low", out_lo, ~m_out);
      check("tick", {1'b0, tick_hi}, {1'b0, m_tick});
      check("tick_active_low_dut", {1'b0, tick_lo}, {1'b0, m_tick});
   endtask

   // called at a negedge; returns at the following negedge
   task automatic cyc(input logic [1:0] cmd);
      led_cmd = cmd;
      @(posedge clk);
      model_edge(int'(cmd));
      #1;
      check_all();
      @(negedge clk);
   endtask

   task automatic do_reset(input int dly);
      #(dly);
      reset_n = 1'b0;
      #1;
      check("async_reset_out", out_hi, 2'b11);
      check("async_reset_out_active_low", out_lo, 2'b00);
      check("async_reset_tick", {1'b0, tick_hi}, 2'b00);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
   endtask

   typedef struct {
      logic [1:0] cmd;
      int         hold;
      logic [1:0] exp;
   } vec_t;

   vec_t       vecs[15];
   logic [1:0] rc;
   int         rh;
   bit         found;

   initial begin
      vecs[0]  = '{2'd1,  8, 2'b11};
      vecs[1]  = '{2'd0,  1, 2'b11};
      vecs[2]  = '{2'd0,  1, 2'b00};
      vecs[3]  = '{2'd1,  1, 2'b00};
      vecs[4]  = '{2'd1,  1, 2'b11};
      vecs[5]  = '{2'd2,  1, 2'b11};
      vecs[6]  = '{2'd2,  1, 2'b10};
      vecs[7]  = '{2'd2, 12, 2'b10};
      vecs[8]  = '{2'd2,  1, 2'b01};
      vecs[9]  = '{2'd2, 11, 2'b01};
      vecs[10] = '{2'd2,  1, 2'b10};
      vecs[11] = '{2'd3,  1, 2'b10};
      vecs[12] = '{2'd3,  1, 2'b10};
      vecs[13] = '{2'd3, 13, 2'b10};
      vecs[14] = '{2'd3,  3, 2'b01};

      reset_n = 1'b0;
      led_cmd = 2'd1;
      model_reset();
      @(posedge clk);
      #1;
      check("reset_out", out_hi, 2'b11);
      check("reset_out_active_low", out_lo, 2'b00);
      check("reset_tick", {1'b0, tick_hi}, 2'b00);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();

      for (int i = 0; i < 15; i++) begin
         for (int k = 0; k < vecs[i].hold; k++) cyc(vecs[i].cmd);
         check($sformatf("vec%0d", i), out_hi, vecs[i].exp);
         check($sformatf("vec%0d_active_low", i), out_lo, ~vecs[i].exp);
      end

      // switch BLINK -> BREATHE on the edge that would consume a tick
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         cyc(2'd2);
         if (tick_hi) found = 1'b1;
      end
      n_cmp++;
      if (!found) begin
         n_bad++;
         $display("FAIL tick_wait: got no tick expected one within 20 cycles");
      end
      cyc(2'd3);
      check("switch_on_tick_no_tick", {1'b0, tick_hi}, 2'b00);
      repeat (5) cyc(2'd3);

      // full triangle including the bounce at 0, then stop at duty 5 and reset
      repeat (80) cyc(2'd3);
      found = 1'b0;
      for (int k = 0; k < 100 && !found; k++) begin
         cyc(2'd3);
         if (duty_of(steps_of(m_j)) == 5) found = 1'b1;
      end
      n_cmp++;
      if (!found) begin
         n_bad++;
         $display("FAIL duty5_wait: got no duty 5 expected one within 100 cycles");
      end
      do_reset(2);
      led_cmd = 2'd3;
      cyc(2'd3);
      check("post_reset_on", out_hi, 2'b11);
      cyc(2'd3);
      check("post_reset_breathe", out_hi, 2'b10);
      check("post_reset_breathe_active_low", out_lo, 2'b01);
      repeat (10) cyc(2'd3);

      for (int s = 0; s < 250; s++) begin
         if ($urandom_range(0, 24) == 0) begin
            do_reset(int'($urandom_range(1, 3)));
         end else begin
            rc = 2'($urandom_range(0, 3));
            rh = int'($urandom_range(1, 40));
            repeat (rh) cyc(rc);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: got no end of test expected within 500000 time units");
      $fatal(1, "timeout");
   end

endmodule
